nvme_sq_issue: RTL and testbench
================================

NVME_SQ_ISSUE -- requirements
Module: nvme_sq_issue

Interface
REQ-001 SHALL have parameter TX_ADDR_BITS, default 10: Tx (submission) buffer write address width.
REQ-002 SHALL have parameter SQ_DEPTH_BITS, default 6: log2 of entries per I/O SQ; TX_ADDR_BITS >= SQ_INDEX_BITS+SQ_DEPTH_BITS+2.
REQ-003 SHALL use one clock and an asynchronous active-low reset: axi_aclk  input  1  clock; axi_aresetn  input  1  async active-low reset.
REQ-004 cmd_valid  input  1  command request; cmd_ready  output  1  command accepted when both high.
REQ-005 cmd_action_id  input  CMD_ACTION_ID_BITS  issuing action; cmd_q_index  input  SQ_INDEX_BITS  physical SQ.
REQ-006 cmd_opcode  input  8; cmd_lba  input  64; cmd_nlb  input  16 (0-based); cmd_prp  input  64.
REQ-007 tx_write_valid  output  1; tx_waddr  output  TX_ADDR_BITS; tx_wdata  output  128  Tx buffer write beat.
REQ-008 sq_doorbell  output  1  one-cycle pulse; sq_doorbell_index  output  SQ_INDEX_BITS; sq_doorbell_tail  output  SQ_DEPTH_BITS.
REQ-009 sq_credit_return  input  1; sq_credit_index  input  SQ_INDEX_BITS  one SQ slot freed (SQ head advanced).
REQ-010 retire_valid  input  1; retire_action_id  input  CMD_ACTION_ID_BITS  one completion consumed by tracker.
REQ-011 issue_pending  output  2**CMD_ACTION_ID_BITS  bit i set while action i has outstanding commands; retire_err  output  1  sticky.

Function
REQ-012 FSM states IDLE, BEAT0, BEAT1, BEAT2, BEAT3, DBELL; IDLE->BEAT0 on accept, BEATn->BEATn+1 each cycle, BEAT3->DBELL, DBELL->IDLE.
REQ-013 cmd_ready SHALL be high only in IDLE, with outstanding[cmd_action_id] < TRACK_NUM and sq_credit[cmd_q_index] != 0, all from registered state.
REQ-014 On accept: capture inputs; cid = {req_idx[action], action_id, q_index} (REQ_ID_BITS+CMD_ACTION_ID_BITS+CMD_QUEUE_ID_BITS = 16 bits); req_idx[action] increments, wrapping TRACK_NUM-1 -> 0.
REQ-015 Beats written one per cycle in BEAT0..BEAT3, tx_waddr = {q_index, tail[q_index], beat[1:0]}, zero-extended.
REQ-016 Beat0: dw0 = {cid, 8'h00, opcode}, dw1 = 32'd1 (NSID), dw2-3 = 0; Beat1: dw6-7 = prp, rest 0; Beat2: dw10-11 = lba, rest 0; Beat3: dw12 = {16'h0, nlb}, rest 0.
REQ-017 DBELL: tail[q] increments mod 2**SQ_DEPTH_BITS; sq_doorbell pulses with the new tail; outstanding[action] +1, sq_credit[q] -1 take effect at accept.
REQ-018 Accept to first tx_write_valid: 1 cycle; accept to sq_doorbell: 5 cycles; throughput one command per 6 cycles.
REQ-019 retire_valid: outstanding[retire_action_id] -1; simultaneous accept and retire on same action: net unchanged.
REQ-020 sq_credit_return: sq_credit[index] +1, saturating at 2**SQ_DEPTH_BITS-1; simultaneous issue/return on same queue: net unchanged.
REQ-021 issue_pending[i] = (outstanding[i] != 0), registered.
REQ-022 Admin queue indices (CMD_SSD0_Q0, CMD_SSD1_Q0) SHALL never be accepted: cmd_ready low for them.

Reset
REQ-023 Reset (including mid-burst) SHALL abort immediately: state IDLE, all outputs 0, req_idx/tail/outstanding 0, sq_credit = 2**SQ_DEPTH_BITS-1 per queue.

Configuration
REQ-024 With NVME_SQ_ISSUE_RETIRE_CHECK_EN defined: retire at outstanding 0 leaves count 0 and sets retire_err (held until reset); undefined: ignored, retire_err tied 0.

Structure
REQ-025 TRACK_NUM, REQ_ID_BITS, CMD_ACTION_ID_BITS, CMD_QUEUE_ID_BITS, queue constants and the FSM state enum SHALL come from the shared nvme_defines package.
REQ-026 No sub-module; single flat block.

Verification
REQ-027 Reset, one command action 3, q 2, opcode 0x02, lba 0x100, nlb 7 -> beats at addr {2,0,0..3}, dw0 = 0x0032_0002 cid {0,3,2}, doorbell index 2 tail 1 at +5.
REQ-028 TRACK_NUM commands on action 1, no retire -> cmd_ready low for action 1, action 2 still accepted; one retire -> action 1 accepted next cycle.
REQ-029 Issue TRACK_NUM+1 on one action with retires -> req_id wraps to 0.
REQ-030 Exhaust q credits (63) -> cmd_ready low; sq_credit_return -> resumes; tail wraps 63 -> 0.
REQ-031 Accept and retire same cycle same action -> issue_pending unchanged; retire at 0 -> retire_err 1 only with macro defined.
REQ-032 Assert axi_aresetn mid BEAT2 -> tx_write_valid 0 immediately, no doorbell, counters cleared.

Source files
------------

// File: rtl/nvme_defines.sv
// Shared NVMe submission-path constants, FSM encoding and command payload type.
package nvme_defines;

    localparam int unsigned TRACK_NUM          = 16;
    localparam int unsigned REQ_ID_BITS        = 8;
    localparam int unsigned CMD_ACTION_ID_BITS = 4;
    localparam int unsigned CMD_QUEUE_ID_BITS  = 4;
    localparam int unsigned CID_BITS           = REQ_ID_BITS + CMD_ACTION_ID_BITS + CMD_QUEUE_ID_BITS;
    localparam int unsigned SQ_INDEX_BITS      = 2;
    localparam int unsigned NUM_SQ             = 2 ** SQ_INDEX_BITS;
    localparam int unsigned NUM_ACTIONS        = 2 ** CMD_ACTION_ID_BITS;
    localparam int unsigned OUT_BITS           = $clog2(TRACK_NUM + 1);

    // Physical SQ map: admin and I/O queues of the two SSDs are interleaved.
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD0_Q0 = 2'd0;
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD1_Q0 = 2'd1;
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD0_Q1 = 2'd2;
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD1_Q1 = 2'd3;

    typedef enum logic [2:0] {
        SQ_IDLE  = 3'd0,
        SQ_BEAT0 = 3'd1,
        SQ_BEAT1 = 3'd2,
        SQ_BEAT2 = 3'd3,
        SQ_BEAT3 = 3'd4,
        SQ_DBELL = 3'd5
    } sq_state_e;

    typedef struct packed {
        logic [SQ_INDEX_BITS-1:0] q;
        logic [63:0]              lba;
        logic [15:0]              nlb;
        logic [63:0]              prp;
    } sq_cmd_t;

    function automatic logic is_admin_q(input logic [SQ_INDEX_BITS-1:0] q);
        return (q == CMD_SSD0_Q0) || (q == CMD_SSD1_Q0);
    endfunction

endpackage

// File: rtl/nvme_sq_issue.sv
// Builds 64-byte NVMe I/O commands into the Tx buffer and rings the SQ doorbell.
// Optional NVME_SQ_ISSUE_RETIRE_CHECK_EN: sticky retire_err on retire underflow.
module nvme_sq_issue
    import nvme_defines::*;
#(
    parameter int unsigned TX_ADDR_BITS  = 10,
    parameter int unsigned SQ_DEPTH_BITS = 6
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CMD_ACTION_ID_BITS-1:0] cmd_action_id,
    input  logic [SQ_INDEX_BITS-1:0]      cmd_q_index,
    input  logic [7:0]                    cmd_opcode,
    input  logic [63:0]                   cmd_lba,
    input  logic [15:0]                   cmd_nlb,
    input  logic [63:0]                   cmd_prp,
    output logic                          tx_write_valid,
    output logic [TX_ADDR_BITS-1:0]       tx_waddr,
    output logic [127:0]                  tx_wdata,
    output logic                          sq_doorbell,
    output logic [SQ_INDEX_BITS-1:0]      sq_doorbell_index,
    output logic [SQ_DEPTH_BITS-1:0]      sq_doorbell_tail,
    input  logic                          sq_credit_return,
    input  logic [SQ_INDEX_BITS-1:0]      sq_credit_index,
    input  logic                          retire_valid,
    input  logic [CMD_ACTION_ID_BITS-1:0] retire_action_id,
    output logic [NUM_ACTIONS-1:0]        issue_pending,
    output logic                          retire_err
);

    localparam logic [SQ_DEPTH_BITS-1:0] CREDIT_MAX = '1;

    sq_state_e                   state, state_d;
    sq_cmd_t                     cur;
    logic                        run;
    logic                        accept;
    logic [CID_BITS-1:0]         cid_now;
    logic [REQ_ID_BITS-1:0]      req_idx     [NUM_ACTIONS];
    logic [OUT_BITS-1:0]         outstanding [NUM_ACTIONS];
    logic [OUT_BITS-1:0]         out_d       [NUM_ACTIONS];
    logic [SQ_DEPTH_BITS-1:0]    tail        [NUM_SQ];
    logic [SQ_DEPTH_BITS-1:0]    credit      [NUM_SQ];
    logic [SQ_DEPTH_BITS-1:0]    credit_d    [NUM_SQ];

    logic                        tx_valid_d;
    logic [TX_ADDR_BITS-1:0]     tx_addr_d;
    logic [127:0]                tx_data_d;
    logic                        db_d;
    logic [SQ_INDEX_BITS-1:0]    db_idx_d;
    logic [SQ_DEPTH_BITS-1:0]    db_tail_d;

    function automatic logic [TX_ADDR_BITS-1:0] beat_addr(input logic [SQ_INDEX_BITS-1:0] q,
                                                           input logic [SQ_DEPTH_BITS-1:0] t,
                                                           input logic [1:0]               b);
        return TX_ADDR_BITS'({q, t, b});
    endfunction

    // run keeps cmd_ready low while reset is held.
    assign cmd_ready = run && (state == SQ_IDLE)
                     && (outstanding[cmd_action_id] < OUT_BITS'(TRACK_NUM))
                     && (credit[cmd_q_index] != '0)
                     && !is_admin_q(cmd_q_index);
    assign accept    = cmd_valid && cmd_ready;
    assign cid_now   = {req_idx[cmd_action_id], cmd_action_id, CMD_QUEUE_ID_BITS'(cmd_q_index)};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= SQ_IDLE;
        else              state <= state_d;
    end

    // Next state plus next values of the registered Tx/doorbell outputs.
    always_comb begin
        state_d    = state;
        tx_valid_d = 1'b0;
        tx_addr_d  = '0;
        tx_data_d  = '0;
        db_d       = 1'b0;
        db_idx_d   = sq_doorbell_index;
        db_tail_d  = sq_doorbell_tail;
        case (state)
            SQ_IDLE: begin
                if (accept) begin
                    state_d    = SQ_BEAT0;
                    tx_valid_d = 1'b1;
                    tx_addr_d  = beat_addr(cmd_q_index, tail[cmd_q_index], 2'd0);
                    tx_data_d  = {64'h0, 32'd1, cid_now, 8'h00, cmd_opcode};
                end
            end
            SQ_BEAT0: begin
                state_d    = SQ_BEAT1;
                tx_valid_d = 1'b1;
                tx_addr_d  = beat_addr(cur.q, tail[cur.q], 2'd1);
                tx_data_d  = {cur.prp, 64'h0};
            end
            SQ_BEAT1: begin
                state_d    = SQ_BEAT2;
                tx_valid_d = 1'b1;
                tx_addr_d  = beat_addr(cur.q, tail[cur.q], 2'd2);
                tx_data_d  = {cur.lba, 64'h0};
            end
            SQ_BEAT2: begin
                state_d    = SQ_BEAT3;
                tx_valid_d = 1'b1;
                tx_addr_d  = beat_addr(cur.q, tail[cur.q], 2'd3);
                tx_data_d  = {96'h0, 16'h0, cur.nlb};
            end
            SQ_BEAT3: begin
                state_d   = SQ_DBELL;
                db_d      = 1'b1;
                db_idx_d  = cur.q;
                db_tail_d = tail[cur.q] + SQ_DEPTH_BITS'(1);
            end
            SQ_DBELL: state_d = SQ_IDLE;
            default:  state_d = SQ_IDLE;
        endcase
    end

    // Per-action outstanding and per-queue credit; simultaneous +1/-1 cancel.
    always_comb begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            out_d[a] = outstanding[a];
            if ((accept && cmd_action_id == CMD_ACTION_ID_BITS'(a))
                && !(retire_valid && retire_action_id == CMD_ACTION_ID_BITS'(a)))
                out_d[a] = outstanding[a] + OUT_BITS'(1);
            else if ((retire_valid && retire_action_id == CMD_ACTION_ID_BITS'(a))
                     && !(accept && cmd_action_id == CMD_ACTION_ID_BITS'(a))
                     && outstanding[a] != '0)
                out_d[a] = outstanding[a] - OUT_BITS'(1);
        end
        for (int q = 0; q < NUM_SQ; q++) begin
            credit_d[q] = credit[q];
            if ((accept && cmd_q_index == SQ_INDEX_BITS'(q))
                && !(sq_credit_return && sq_credit_index == SQ_INDEX_BITS'(q)))
                credit_d[q] = credit[q] - SQ_DEPTH_BITS'(1);
            else if ((sq_credit_return && sq_credit_index == SQ_INDEX_BITS'(q))
                     && !(accept && cmd_q_index == SQ_INDEX_BITS'(q))
                     && credit[q] != CREDIT_MAX)
                credit_d[q] = credit[q] + SQ_DEPTH_BITS'(1);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            run               <= 1'b0;
            cur               <= '0;
            tx_write_valid    <= 1'b0;
            tx_waddr          <= '0;
            tx_wdata          <= '0;
            sq_doorbell       <= 1'b0;
            sq_doorbell_index <= '0;
            sq_doorbell_tail  <= '0;
            issue_pending     <= '0;
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                req_idx[a]     <= '0;
                outstanding[a] <= '0;
            end
            for (int q = 0; q < NUM_SQ; q++) begin
                tail[q]   <= '0;
                credit[q] <= CREDIT_MAX;
            end
        end else begin
            run               <= 1'b1;
            tx_write_valid    <= tx_valid_d;
            tx_waddr          <= tx_addr_d;
            tx_wdata          <= tx_data_d;
            sq_doorbell       <= db_d;
            sq_doorbell_index <= db_idx_d;
            sq_doorbell_tail  <= db_tail_d;
            if (accept) begin
                cur <= '{q: cmd_q_index, lba: cmd_lba, nlb: cmd_nlb, prp: cmd_prp};
                req_idx[cmd_action_id] <= (req_idx[cmd_action_id] == REQ_ID_BITS'(TRACK_NUM - 1))
                                        ? '0 : req_idx[cmd_action_id] + REQ_ID_BITS'(1);
            end
            if (state == SQ_BEAT3)
                tail[cur.q] <= tail[cur.q] + SQ_DEPTH_BITS'(1);
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                outstanding[a]   <= out_d[a];
                issue_pending[a] <= (out_d[a] != '0);
            end
            for (int q = 0; q < NUM_SQ; q++)
                credit[q] <= credit_d[q];
        end
    end

`ifdef NVME_SQ_ISSUE_RETIRE_CHECK_EN
    logic underflow;

    assign underflow = retire_valid && (outstanding[retire_action_id] == '0)
                     && !(accept && cmd_action_id == retire_action_id);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)   retire_err <= 1'b0;
        else if (underflow) retire_err <= 1'b1;
    end
`else
    assign retire_err = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_sq_issue.sv
// Self-checking bench for nvme_sq_issue: directed scenarios plus random traffic vs a latency-level model.
module tb_nvme_sq_issue;
    import nvme_defines::*;

    localparam int DEPTH  = 64;
    localparam int CR_MAX = 63;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_action_id = '0;
    logic [1:0]   cmd_q_index = 2'd2;
    logic [7:0]   cmd_opcode = '0;
    logic [63:0]  cmd_lba = '0;
    logic [15:0]  cmd_nlb = '0;
    logic [63:0]  cmd_prp = '0;
    logic         tx_write_valid;
    logic [9:0]   tx_waddr;
    logic [127:0] tx_wdata;
    logic         sq_doorbell;
    logic [1:0]   sq_doorbell_index;
    logic [5:0]   sq_doorbell_tail;
    logic         sq_credit_return = 1'b0;
    logic [1:0]   sq_credit_index = '0;
    logic         retire_valid = 1'b0;
    logic [3:0]   retire_action_id = '0;
    logic [15:0]  issue_pending;
    logic         retire_err;

    always #5 axi_aclk = ~axi_aclk;

    nvme_sq_issue #(.TX_ADDR_BITS(10), .SQ_DEPTH_BITS(6)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_action_id(cmd_action_id), .cmd_q_index(cmd_q_index),
        .cmd_opcode(cmd_opcode), .cmd_lba(cmd_lba), .cmd_nlb(cmd_nlb), .cmd_prp(cmd_prp),
        .tx_write_valid(tx_write_valid), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
        .sq_doorbell(sq_doorbell), .sq_doorbell_index(sq_doorbell_index),
        .sq_doorbell_tail(sq_doorbell_tail),
        .sq_credit_return(sq_credit_return), .sq_credit_index(sq_credit_index),
        .retire_valid(retire_valid), .retire_action_id(retire_action_id),
        .issue_pending(issue_pending), .retire_err(retire_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: counts per action/queue and a phase counter 1..5 after an accept.
    int   m_out [16];
    int   m_req [16];
    int   m_cred [4];
    int   m_tail [4];
    int   m_phase;
    bit   m_err;
    int   c_q, c_tail, c_cid;
    logic [7:0]  c_op;
    logic [63:0] c_lba, c_prp;
    logic [15:0] c_nlb;
    logic [7:0]  nx_op;
    logic [63:0] nx_lba, nx_prp;
    logic [15:0] nx_nlb;

    function automatic bit is_admin(input int q);
        return (q == int'(CMD_SSD0_Q0)) || (q == int'(CMD_SSD1_Q0));
    endfunction

    function automatic logic [127:0] exp_beat(input int n);
        logic [15:0] cid;
        cid = 16'(c_cid);
        case (n)
            0:       return {64'h0, 32'd1, cid, 8'h00, c_op};
            1:       return {c_prp, 64'h0};
            2:       return {c_lba, 64'h0};
            default: return {96'h0, 16'h0, c_nlb};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_out[i] = 0;
            m_req[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_cred[i] = CR_MAX;
            m_tail[i] = 0;
        end
        m_phase = 0;
        m_err   = 1'b0;
    endtask

    task automatic rand_fields();
        nx_op  = 8'($urandom);
        nx_lba = {$urandom, $urandom};
        nx_nlb = 16'($urandom);
        nx_prp = {$urandom, $urandom};
    endtask

    // One clock: drive at negedge, predict ready, advance model at posedge, check at next negedge.
    task automatic cycle(input bit v, input int act, input int q, input bit rv, input int ract,
                         input bit cr, input int cq);
        bit          exp_ready, acc, inc, dec;
        logic [15:0] pend;
        cmd_valid        = v;
        cmd_action_id    = 4'(act);
        cmd_q_index      = 2'(q);
        cmd_opcode       = nx_op;
        cmd_lba          = nx_lba;
        cmd_nlb          = nx_nlb;
        cmd_prp          = nx_prp;
        retire_valid     = rv;
        retire_action_id = 4'(ract);
        sq_credit_return = cr;
        sq_credit_index  = 2'(cq);
        #1;
        exp_ready = (m_phase == 0) && (m_out[act] < int'(TRACK_NUM)) && (m_cred[q] > 0) && !is_admin(q);
        check("cmd_ready", cmd_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge axi_aclk);
        if (m_phase == 4) begin
            m_phase = 5;
            m_tail[c_q] = (m_tail[c_q] + 1) % DEPTH;
        end else if (m_phase == 5) begin
            m_phase = 0;
        end else if (m_phase != 0) begin
            m_phase++;
        end else if (acc) begin
            m_phase = 1;
            c_q    = q;
            c_tail = m_tail[q];
            c_cid  = m_req[act] * 256 + act * 16 + q;
            c_op   = nx_op;
            c_lba  = nx_lba;
            c_nlb  = nx_nlb;
            c_prp  = nx_prp;
            m_req[act] = (m_req[act] + 1) % int'(TRACK_NUM);
        end
        for (int a = 0; a < 16; a++) begin
            inc = acc && (act == a);
            dec = rv && (ract == a);
            if (inc && !dec) m_out[a]++;
            else if (dec && !inc) begin
                if (m_out[a] == 0) begin
`ifdef NVME_SQ_ISSUE_RETIRE_CHECK_EN
                    m_err = 1'b1;
`endif
                end else m_out[a]--;
            end
        end
        for (int k = 0; k < 4; k++) begin
            inc = cr && (cq == k);
            dec = acc && (q == k);
            if (dec && !inc) m_cred[k]--;
            else if (inc && !dec && m_cred[k] < CR_MAX) m_cred[k]++;
        end
        @(negedge axi_aclk);
        check("tx_valid", tx_write_valid, (m_phase >= 1 && m_phase <= 4));
        if (m_phase >= 1 && m_phase <= 4) begin
            check("tx_waddr", tx_waddr, c_q * DEPTH * 4 + c_tail * 4 + (m_phase - 1));
            check("tx_wdata", tx_wdata, exp_beat(m_phase - 1));
        end
        check("doorbell", sq_doorbell, m_phase == 5);
        if (m_phase == 5) begin
            check("db_index", sq_doorbell_index, c_q);
            check("db_tail", sq_doorbell_tail, (c_tail + 1) % DEPTH);
        end
        for (int a = 0; a < 16; a++) pend[a] = (m_out[a] != 0);
        check("issue_pending", issue_pending, pend);
        check("retire_err", retire_err, m_err);
    endtask

    task automatic idle();
        cycle(0, 0, 2, 0, 0, 0, 0);
    endtask

    task automatic issue(input int act, input int q, input bit rv, input int ract);
        rand_fields();
        cycle(1, act, q, rv, ract, 0, 0);
        repeat (5) idle();
    endtask

    task automatic do_reset();
        axi_aresetn      = 1'b0;
        cmd_valid        = 1'b0;
        retire_valid     = 1'b0;
        sq_credit_return = 1'b0;
        #1;
        check("rst_tx_valid", tx_write_valid, 0);
        check("rst_waddr", tx_waddr, 0);
        check("rst_doorbell", sq_doorbell, 0);
        check("rst_pending", issue_pending, 0);
        check("rst_err", retire_err, 0);
        check("rst_ready", cmd_ready, 0);
        model_reset();
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
    endtask

    initial begin
        bit exp_err;
        rand_fields();
        #2;
        do_reset();

        // Single reference command.
        nx_op  = 8'h02;
        nx_lba = 64'h100;
        nx_nlb = 16'd7;
        nx_prp = 64'h1234_5678_9abc_def0;
        cycle(1, 3, 2, 0, 0, 0, 0);
        check("t1_waddr", tx_waddr, 10'h200);
        check("t1_dw0", tx_wdata[31:0], 32'h0032_0002);
        repeat (4) idle();
        check("t1_db", sq_doorbell, 1);
        check("t1_db_idx", sq_doorbell_index, 2);
        check("t1_db_tail", sq_doorbell_tail, 1);
        idle();

        // Fill action 1 to TRACK_NUM outstanding.
        for (int i = 0; i < int'(TRACK_NUM); i++) issue(1, 2 + (i % 2), 0, 0);
        cycle(1, 1, 2, 0, 0, 0, 0);
        check("t2_full", cmd_ready, 0);
        issue(2, 3, 0, 0);
        check("t2_act2", issue_pending[2], 1);
        cycle(0, 0, 2, 1, 1, 0, 0);
        rand_fields();
        cycle(1, 1, 2, 0, 0, 0, 0);
        check("t2_resume", tx_write_valid, 1);
        repeat (5) idle();

        // req_id wrap.
        do_reset();
        for (int i = 0; i < int'(TRACK_NUM); i++) issue(4, 2, 1, 4);
        rand_fields();
        cycle(1, 4, 3, 1, 4, 0, 0);
        check("t3_wrap", tx_wdata[31:24], 0);
        repeat (5) idle();

        // Credit exhaustion, return and tail wrap.
        do_reset();
        for (int i = 0; i < CR_MAX; i++) issue(i % 4, 2, 1, i % 4);
        cycle(1, 0, 2, 0, 0, 0, 0);
        check("t4_empty", cmd_ready, 0);
        cycle(0, 0, 2, 0, 0, 1, 2);
        rand_fields();
        cycle(1, 0, 2, 0, 0, 0, 0);
        check("t4_resume", tx_write_valid, 1);
        repeat (4) idle();
        check("t4_db", sq_doorbell, 1);
        check("t4_tail_wrap", sq_doorbell_tail, 0);
        idle();

        // Accept+retire same action, then retire underflow.
        issue(5, 3, 0, 0);
        rand_fields();
        cycle(1, 5, 3, 1, 5, 0, 0);
        check("t5_pend_hold", issue_pending[5], 1);
        repeat (5) idle();
        cycle(0, 0, 2, 1, 5, 0, 0);
        check("t5_pend_clr", issue_pending[5], 0);
        cycle(0, 0, 2, 1, 9, 0, 0);
`ifdef NVME_SQ_ISSUE_RETIRE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("t5_err", retire_err, exp_err);

        // Reset in the middle of a burst.
        do_reset();
        rand_fields();
        cycle(1, 6, 3, 0, 0, 0, 0);
        idle();
        idle();
        check("t6_pre", tx_write_valid, 1);
        do_reset();
        repeat (6) idle();
        rand_fields();
        cycle(1, 6, 3, 0, 0, 0, 0);
        check("t6_addr", tx_waddr, 10'h300);
        check("t6_cid", tx_wdata[31:16], 16'h0063);
        repeat (5) idle();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            rand_fields();
            cycle($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
